// File: rtl/stream_feeder_pkg.sv
// -----------------------------------------------------------------------------
// stream_feeder_pkg
//
// Shared types and sizing helpers for the stream feeder and its RAM.
//
// Contents:
//   feeder_state_t  - feeder control state (LOAD, READY, SERVE)
//   layer_depth()   - words per pass for a CI x SIZE x SIZE layer
//   DEF_*           - default sizing for the 3x227x227 IFM tensor
// -----------------------------------------------------------------------------
package stream_feeder_pkg;

  // LOAD  : accepting loader words until the buffer is full
  // READY : buffer full, waiting for the first start
  // SERVE : answering read requests, address wraps each pass
  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    READY = 2'd1,
    SERVE = 2'd2
  } feeder_state_t;

  // Number of words in one pass over a square input feature map.
  function automatic int unsigned layer_depth(input int unsigned ci,
                                              input int unsigned ifm_size);
    return ci * ifm_size * ifm_size;
  endfunction

  localparam int unsigned DEF_DATA_W   = 16;
  localparam int unsigned DEF_CI       = 3;
  localparam int unsigned DEF_IFM_SIZE = 227;
  localparam int unsigned DEF_DEPTH    = layer_depth(DEF_CI, DEF_IFM_SIZE);
  localparam int unsigned DEF_ADDR_W   = 18;
  localparam int unsigned DEF_CNT_W    = 8;

endpackage : stream_feeder_pkg

// File: rtl/stream_feeder_ram.sv
// -----------------------------------------------------------------------------
// feeder_ram
//
// Single-port synchronous RAM, DATA_W x DEPTH. One shared address; a write
// and a read are never requested in the same cycle by the feeder because
// writes happen only while loading and reads only while serving.
//
// Ports:
//   clk1   in   clock
//   we     in   write enable: mem[addr] <= wdata
//   re     in   read enable:  rdata <= mem[addr] (visible next cycle)
//   addr   in   word address
//   wdata  in   write data
//   rdata  out  registered read data (holds its value when re=0)
// -----------------------------------------------------------------------------
module feeder_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 154587,
  parameter int ADDR_W = 18
) (
  input  logic              clk1,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array and its read register have no reset; clearing a RAM
  // costs a write per word and the feeder tracks validity with `loaded`.
  always_ff @(posedge clk1) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule : feeder_ram

// File: rtl/stream_feeder.sv
// -----------------------------------------------------------------------------
// stream_feeder
//
// Responder for the accelerator's read-request interface. A loader fills the
// internal buffer once (DEPTH words); after `start` every accepted rd_req
// returns the next stored word exactly one cycle later, and the read address
// wraps so the tensor can be streamed any number of times.
//
// Ports:
//   clk1        in   sole clock
//   rst         in   synchronous reset, active-high
//   load_valid  in   loader word present
//   load_data   in   loader word
//   load_ready  out  loader word accepted this cycle (LOAD state only)
//   start       in   1-cycle pulse: begin/restart serving from address 0
//   rd_req      in   consumer read request
//   rd_data     out  returned word, 0 when rd_valid=0
//   rd_valid    out  rd_data valid, one cycle after the accepted rd_req
//   pass_done   out  pulse with the rd_valid of word DEPTH-1
//   pass_cnt    out  completed passes, wraps modulo 2**CNT_W
//   loaded      out  buffer full, ready to serve
//   proto_err   out  sticky protocol error flag (cleared by reset only)
// -----------------------------------------------------------------------------
module stream_feeder
  import stream_feeder_pkg::*;
#(
  parameter int DATA_W = int'(DEF_DATA_W),
  parameter int DEPTH  = int'(DEF_DEPTH),
  parameter int ADDR_W = int'(DEF_ADDR_W),
  parameter int CNT_W  = int'(DEF_CNT_W)
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  input  logic              start,
  input  logic              rd_req,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              pass_done,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic              loaded,
  output logic              proto_err
);

  feeder_state_t     state_q, state_d;

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_q;

  logic              wr_en;
  logic              rd_en;
  logic              restart;
  logic              err_evt;
  logic              wr_last;
  logic              rd_last;

  logic              rd_valid_q;
  logic              pass_done_q;
  logic              loaded_q;
  logic              proto_err_q;
  logic [CNT_W-1:0]  pass_cnt_q;

  assign wr_last = (wr_ptr == ADDR_W'(DEPTH - 1));
  assign rd_last = (rd_ptr == ADDR_W'(DEPTH - 1));

  // ---------------------------------------------------------------------------
  // Next-state and per-cycle strobes. While rst is high every strobe is held
  // low so nothing is written, read or flagged in the reset cycle, and
  // load_ready reads 0 until reset is released.
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default before the case; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    state_d    = state_q;
    load_ready = 1'b0;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    restart    = 1'b0;
    err_evt    = 1'b0;

    if (!rst) begin
      unique case (state_q)
        LOAD: begin
          load_ready = 1'b1;
          wr_en      = load_valid;
          err_evt    = start;
          if (load_valid && wr_last) begin
            state_d = READY;
          end
        end

        READY: begin
          err_evt = load_valid | rd_req;
          if (start) begin
            state_d = SERVE;
            restart = 1'b1;
          end
        end

        SERVE: begin
          err_evt = load_valid;
          rd_en   = rd_req;
          // A read in the same cycle as start wins; start is dropped.
          restart = start & ~rd_req;
        end

        default: begin
          state_d = LOAD;
        end
      endcase
    end
  end

  // NOTE: reset is synchronous here: it is just the highest-priority branch
  // of the clocked block, not part of the sensitivity list.
  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers and status flags.
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk1) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rd_valid_q  <= 1'b0;
      pass_done_q <= 1'b0;
      pass_cnt_q  <= '0;
      loaded_q    <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_last ? '0 : wr_ptr + ADDR_W'(1);
      end

      if (wr_en && wr_last) begin
        loaded_q <= 1'b1;
      end

      if (restart) begin
        rd_ptr <= '0;
      end else if (rd_en) begin
        rd_ptr <= rd_last ? '0 : rd_ptr + ADDR_W'(1);
      end

      // The RAM output register is loaded on the same edge, so valid, the
      // end-of-pass pulse and the pass count all line up with the word.
      rd_valid_q  <= rd_en;
      pass_done_q <= rd_en & rd_last;
      if (rd_en && rd_last) begin
        pass_cnt_q <= pass_cnt_q + CNT_W'(1);
      end

      if (err_evt) begin
        proto_err_q <= 1'b1;
      end
    end
  end

  // Loader owns the address while loading; otherwise the read pointer does.
  assign ram_addr = (state_q == LOAD) ? wr_ptr : rd_ptr;

  feeder_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk1  (clk1),
    .we    (wr_en),
    .re    (rd_en),
    .addr  (ram_addr),
    .wdata (load_data),
    .rdata (ram_q)
  );

  // The RAM register holds stale data between reads; mask it so rd_data is
  // zero whenever it is not valid.
  assign rd_data   = rd_valid_q ? ram_q : '0;
  assign rd_valid  = rd_valid_q;
  assign pass_done = pass_done_q;
  assign pass_cnt  = pass_cnt_q;
  assign loaded    = loaded_q;
  assign proto_err = proto_err_q;

endmodule : stream_feeder

// File: tb/tb_stream_feeder.sv
// -----------------------------------------------------------------------------
// tb_stream_feeder
//
// Self-checking bench for stream_feeder with DEPTH=8, DATA_W=16. A reference
// model tracks the stored tensor, the index of the next word to be served,
// the number of completed passes and the sticky error flag; each serve cycle
// the DUT's {rd_valid, rd_data, pass_done, pass_cnt, proto_err} is compared
// with the model's prediction.
// -----------------------------------------------------------------------------
module tb_stream_feeder;

  localparam int DW = 16;
  localparam int D  = 8;
  localparam int AW = 3;
  localparam int CW = 8;

  logic          clk1 = 1'b0;
  logic          rst;
  logic          load_valid;
  logic [DW-1:0] load_data;
  logic          load_ready;
  logic          start;
  logic          rd_req;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          pass_done;
  logic [CW-1:0] pass_cnt;
  logic          loaded;
  logic          proto_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [DW-1:0] model_mem [D];
  int            model_idx;
  int            model_pass;
  bit            model_err;

  stream_feeder #(
    .DATA_W (DW),
    .DEPTH  (D),
    .ADDR_W (AW),
    .CNT_W  (CW)
  ) dut (
    .clk1       (clk1),
    .rst        (rst),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .start      (start),
    .rd_req     (rd_req),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .pass_done  (pass_done),
    .pass_cnt   (pass_cnt),
    .loaded     (loaded),
    .proto_err  (proto_err)
  );

  always #5 clk1 = ~clk1;

  // Advance one clock and sample 1 time unit after the edge.
  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  // Observed serve-side outputs packed as {valid, data, pass_done, cnt, err}.
  function automatic logic [26:0] obs();
    return {rd_valid, rd_data, pass_done, pass_cnt, proto_err};
  endfunction

  // Expected outputs after one SERVE cycle with the given inputs.
  function automatic logic [26:0] model_step(input bit req, input bit st,
                                             input bit lv);
    logic          v;
    logic [DW-1:0] d;
    logic          pd;
    v  = 1'b0;
    d  = '0;
    pd = 1'b0;
    if (req) begin
      v  = 1'b1;
      d  = model_mem[model_idx];
      pd = (model_idx == D - 1);
      model_idx = (model_idx + 1) % D;
      if (pd) model_pass++;
    end else if (st) begin
      model_idx = 0;
    end
    if (lv) model_err = 1'b1;
    return {v, d, pd, CW'(model_pass % 256), model_err};
  endfunction

  // Drive one cycle of inputs, then return inputs to idle.
  task automatic apply(input bit req, input bit st, input bit lv);
    rd_req     = req;
    start      = st;
    load_valid = lv;
    load_data  = DW'($urandom);
    tick();
    rd_req     = 1'b0;
    start      = 1'b0;
    load_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;
    start      = 1'b0;
    rd_req     = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    model_idx  = 0;
    model_pass = 0;
    model_err  = 1'b0;
  endtask

  // Fill the buffer with base+i (or random words); checks the handshake.
  task automatic load_buf(input logic [DW-1:0] base, input bit rnd);
    for (int i = 0; i < D; i++) begin
      model_mem[i] = rnd ? DW'($urandom) : base + DW'(i);
      n_checks++;
      if (load_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL load_ready word %0d: got %b expected 1", i, load_ready);
      end
      load_valid = 1'b1;
      load_data  = model_mem[i];
      tick();
    end
    load_valid = 1'b0;
    n_checks++;
    if ({loaded, load_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL loaded_after_fill: got loaded=%b load_ready=%b expected 1/0",
               loaded, load_ready);
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;
    start      = 1'b0;
    rd_req     = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({load_ready, loaded, obs()} !== 29'd0) begin
      n_fail++;
      $display("FAIL reset_values: got ready=%b loaded=%b obs=%h expected all 0",
               load_ready, loaded, obs());
    end
    rst = 1'b0;
    #1;
    model_idx  = 0;
    model_pass = 0;
    model_err  = 1'b0;
    n_checks++;
    if (load_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_reset: got %b expected 1", load_ready);
    end
    // start while loading is illegal
    apply(1'b0, 1'b1, 1'b0);
    n_checks++;
    if ({proto_err, load_ready, rd_valid} !== 3'b110) begin
      n_fail++;
      $display("FAIL start_in_load: got err/ready/valid=%b%b%b expected 110",
               proto_err, load_ready, rd_valid);
    end
  endtask

  task automatic test_load_serve();
    logic [26:0] e;
    do_reset();
    load_buf(16'h0010, 1'b0);
    apply(1'b0, 1'b1, 1'b0);
    e = model_step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < D; i++) begin
      apply(1'b1, 1'b0, 1'b0);
      e = model_step(1'b1, 1'b0, 1'b0);
      n_checks++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL load_serve[%0d]: got %h expected %h", i, obs(), e);
      end
    end
    apply(1'b0, 1'b0, 1'b0);
    n_checks++;
    if ({rd_valid, rd_data, pass_cnt} !== {1'b0, 16'h0, 8'd1}) begin
      n_fail++;
      $display("FAIL serve_idle: got valid=%b data=%h cnt=%0d expected 0/0000/1",
               rd_valid, rd_data, pass_cnt);
    end
  endtask

  task automatic test_wrap();
    logic [26:0] e;
    int pulses = 0;
    apply(1'b0, 1'b1, 1'b0);
    e = model_step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      apply(1'b1, 1'b0, 1'b0);
      e = model_step(1'b1, 1'b0, 1'b0);
      if (pass_done === 1'b1) pulses++;
      n_checks++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL wrap[%0d]: got %h expected %h", i, obs(), e);
      end
    end
    n_checks++;
    if (pulses != 2) begin
      n_fail++;
      $display("FAIL wrap_pulses: got %0d expected 2", pulses);
    end
  endtask

  task automatic test_gaps_restart();
    logic [26:0] e;
    apply(1'b0, 1'b1, 1'b0);
    e = model_step(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      int gap = $urandom_range(1, 4);
      for (int g = 0; g < gap; g++) begin
        apply(1'b0, 1'b0, 1'b0);
        e = model_step(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs() !== e) begin
          n_fail++;
          $display("FAIL gap_idle[%0d.%0d]: got %h expected %h", k, g, obs(), e);
        end
      end
      apply(1'b1, 1'b0, 1'b0);
      e = model_step(1'b1, 1'b0, 1'b0);
      n_checks++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL gap_read[%0d]: got %h expected %h", k, obs(), e);
      end
    end
    // mid-pass restart
    apply(1'b0, 1'b1, 1'b0);
    e = model_step(1'b0, 1'b1, 1'b0);
    apply(1'b1, 1'b0, 1'b0);
    e = model_step(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (obs() !== e || rd_data !== 16'h0010 || pass_done !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_read: got %h expected %h", obs(), e);
    end
  endtask

  task automatic test_collision();
    logic [26:0] e;
    apply(1'b0, 1'b1, 1'b0);
    e = model_step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, 1'b0, 1'b0);
      e = model_step(1'b1, 1'b0, 1'b0);
    end
    apply(1'b1, 1'b1, 1'b0);
    e = model_step(1'b1, 1'b1, 1'b0);
    n_checks++;
    if (obs() !== e || rd_data !== 16'h0015) begin
      n_fail++;
      $display("FAIL collision_read: got %h expected %h", obs(), e);
    end
    apply(1'b1, 1'b0, 1'b0);
    e = model_step(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (obs() !== e || rd_data !== 16'h0016) begin
      n_fail++;
      $display("FAIL collision_next: got %h expected %h", obs(), e);
    end
    // read request while READY
    do_reset();
    load_buf(16'h0010, 1'b0);
    apply(1'b1, 1'b0, 1'b0);
    n_checks++;
    if ({rd_valid, rd_data, proto_err} !== {1'b0, 16'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL read_in_ready: got valid=%b data=%h err=%b expected 0/0000/1",
               rd_valid, rd_data, proto_err);
    end
    model_err = 1'b1;
    for (int i = 0; i < 3; i++) apply(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (proto_err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: got %b expected 1", proto_err);
    end
  endtask

  task automatic test_reset_mid_serve();
    logic [26:0] e;
    apply(1'b0, 1'b1, 1'b0);
    e = model_step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 1'b0, 1'b0);
      e = model_step(1'b1, 1'b0, 1'b0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    model_idx  = 0;
    model_pass = 0;
    model_err  = 1'b0;
    n_checks++;
    if ({obs(), loaded, load_ready} !== {27'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL mid_serve_reset: got obs=%h loaded=%b ready=%b expected 0/0/1",
               obs(), loaded, load_ready);
    end
    load_buf(16'h00A0, 1'b0);
    apply(1'b0, 1'b1, 1'b0);
    e = model_step(1'b0, 1'b1, 1'b0);
    apply(1'b1, 1'b0, 1'b0);
    e = model_step(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (obs() !== e || rd_data !== 16'h00A0) begin
      n_fail++;
      $display("FAIL reload_first: got %h expected %h", obs(), e);
    end
  endtask

  task automatic test_loader_protocol();
    logic [26:0] e;
    do_reset();
    load_valid = 1'b1;
    for (int i = 0; i < D; i++) begin
      model_mem[i] = 16'h0030 + DW'(i);
      load_data    = model_mem[i];
      tick();
    end
    load_data = 16'hDEAD;
    n_checks++;
    if (load_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ninth_ready: got %b expected 0", load_ready);
    end
    tick();
    load_valid = 1'b0;
    model_err  = 1'b1;
    n_checks++;
    if (proto_err !== 1'b1) begin
      n_fail++;
      $display("FAIL extra_load_err: got %b expected 1", proto_err);
    end
    apply(1'b0, 1'b1, 1'b0);
    e = model_step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < D; i++) begin
      apply(1'b1, 1'b0, 1'b0);
      e = model_step(1'b1, 1'b0, 1'b0);
      n_checks++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL readback[%0d]: got %h expected %h", i, obs(), e);
      end
    end
  endtask

  task automatic test_random();
    logic [26:0] e;
    do_reset();
    load_buf('0, 1'b1);
    apply(1'b0, 1'b1, 1'b0);
    e = model_step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 64; i++) begin
      bit req = ($urandom_range(0, 3) != 0);
      bit st  = ($urandom_range(0, 7) == 0);
      bit lv  = ($urandom_range(0, 15) == 0);
      apply(req, st, lv);
      e = model_step(req, st, lv);
      n_checks++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL random[%0d] req=%b st=%b lv=%b: got %h expected %h",
                 i, req, st, lv, obs(), e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_serve();
    test_wrap();
    test_gaps_restart();
    test_collision();
    test_reset_mid_serve();
    test_loader_protocol();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_stream_feeder

// File: doc/stream_feeder.md
Name: stream_feeder

Overview:
- Synthesizable responder for the accelerator's read-request interface (ifm_read/ifm, wgt_read/wgt style).
- An external loader fills an internal buffer once. After `start`, each 1-cycle `rd_req` returns the next word one cycle later, in sequential order.
- The read address wraps so a stored tensor can be streamed repeatedly.
- One instance serves IFM data; separate instances serve each weight set.

Parameters:
- DATA_W, 16, word width (matches IFM_WIDTH/WEIGHT_WIDTH).
- DEPTH, 154587, words per pass (CI*IFM_SIZE*IFM_SIZE for 3x227x227).
- ADDR_W, 18, address/counter width; must satisfy 2**ADDR_W >= DEPTH.
- CNT_W, 8, width of the pass counter.

Ports:
- clk1  in  1  sole clock.
- rst  in  1  synchronous reset, active-high.
- load_valid  in  1  loader word present.
- load_data  in  DATA_W  loader word.
- load_ready  out  1  feeder accepts a loader word this cycle.
- start  in  1  1-cycle pulse; begin/restart serving from address 0.
- rd_req  in  1  consumer read request (ifm_read/wgt_read).
- rd_data  out  DATA_W  returned word; 0 when rd_valid=0.
- rd_valid  out  1  rd_data valid (one cycle after the accepted rd_req).
- pass_done  out  1  1-cycle pulse, coincident with rd_valid of word DEPTH-1.
- pass_cnt  out  CNT_W  completed passes, wraps modulo 2**CNT_W.
- loaded  out  1  buffer full, ready to serve.
- proto_err  out  1  sticky protocol error flag.

Behaviour:
- One clock (clk1). Reset is synchronous and active-high (rst). No other clock or reset.
- Reset values: load_ready=0, rd_data=0, rd_valid=0, pass_done=0, pass_cnt=0, loaded=0, proto_err=0, FSM=LOAD, wr_ptr=0, rd_ptr=0.
- Buffer contents are not cleared by reset, but `loaded` clears, so a full reload is mandatory after any reset.
- FSM states: LOAD, READY, SERVE.
- LOAD:
  - load_ready=1.
  - load_valid writes load_data to mem[wr_ptr], then wr_ptr++.
  - The write at wr_ptr=DEPTH-1 moves the FSM to READY and sets loaded=1 next cycle.
- READY:
  - load_ready=0.
  - start moves the FSM to SERVE with rd_ptr=0.
  - rd_req in READY is ignored and sets proto_err.
- SERVE:
  - rd_req in cycle t gives rd_valid=1 and rd_data=mem[rd_ptr] in cycle t+1, then rd_ptr++. Latency is exactly 1 cycle.
  - Back-to-back rd_req gives one word per cycle with no bubbles.
  - Read at rd_ptr=DEPTH-1: rd_ptr wraps to 0; pass_done=1 and pass_cnt++ in the same cycle as that word's rd_valid.
  - start with rd_req=0: rd_ptr resets to 0 and the FSM stays in SERVE (mid-pass restart, no pass_done).
  - start and rd_req in the same cycle: the read is served from the current rd_ptr and start is ignored.
- Outside SERVE: rd_valid=0 and rd_data=0 regardless of inputs.
- load_valid while not in LOAD: ignored, no write, sets proto_err.
- start while in LOAD: ignored, sets proto_err.
- proto_err clears only on reset.
- The memory is a single-port synchronous-read array. Only LOAD writes and only SERVE reads, so there is never a read/write conflict.

Decomposition:
- Shared package: feeder_state_t enum (LOAD, READY, SERVE) and a DEPTH-from-layer-shape helper constant function.
- One sub-module: feeder_ram (single-port synchronous RAM, DATA_W x DEPTH, synchronous read, write enable).
- FSM, pointers and flags stay in stream_feeder.

Test Plan:
- Use DEPTH=8, DATA_W=16 for all scenarios.
- Load and serve: load 0x10..0x17, start, 8 consecutive rd_req -> rd_data 0x10..0x17 at t+1..t+8; pass_done coincides with 0x17; pass_cnt=1.
- Wrap: 20 consecutive rd_req after start -> sequence 0x10..0x17, 0x10..0x17, 0x10..0x13; pass_done pulses twice; pass_cnt=2.
- Gaps and restart: rd_req at 3 scattered cycles -> 0x10, 0x11, 0x12, each exactly 1 cycle after its request. Then start alone -> next rd_req returns 0x10, no pass_done.
- Collision and illegal access: start and rd_req in the same cycle at rd_ptr=5 -> returns 0x15, next read 0x16. rd_req in READY -> rd_valid stays 0, proto_err=1 and stays 1.
- Reset mid-serve: assert rst at rd_ptr=4 -> next cycle all outputs 0, loaded=0, load_ready=1. After reloading 0xA0..0xA7 and start, first read returns 0xA0.
- Loader protocol: load_valid held high after 8 writes -> load_ready=0 on the 9th cycle, no write occurs, proto_err=1, contents unchanged on readback.
